// File: rtl/thymesisflow_credit_pkg.sv
// thymesisflow_credit_pkg: shared state encodings, default sizes and index-width helper
package thymesisflow_credit_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_MSB  = 5;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/thymesisflow_rr_arbiter.sv
// thymesisflow_rr_arbiter: combinational round-robin pick, first valid at or after rr_ptr
module thymesisflow_rr_arbiter
    import thymesisflow_credit_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IW-1:0]   rr_ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic found;
    int   p;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        p     = 0;
        for (int k = 0; k < NREQ; k++) begin
            p = (int'(rr_ptr_i) + k) % NREQ;
            if (enable_i && !found && req_valid_i[p]) begin
                found    = 1'b1;
                gnt_o[p] = 1'b1;
                idx_o    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/thymesisflow_credit_arb.sv
// thymesisflow_credit_arb: round-robin grant of a shared TLX credit pool with
// overflow detection that halts granting until the pool is re-initialised.
module thymesisflow_credit_arb
    import thymesisflow_credit_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int MSB  = DEF_MSB,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic            clock_i,
    input  logic            resetn_i,
    input  logic            init_load_i,
    input  logic [MSB:0]    initial_credits_i,
    input  logic [MSB:0]    returned_credits_i,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] req_ready_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic [MSB:0]    credits_available_o,
    output logic [1:0]      state_o,
    output logic            credit_overflow_o
);

    state_e          state_q;
    logic [MSB:0]    pool_q;
    logic [IW-1:0]   rr_ptr_q;
    logic            ovf_q;
    logic            enable;
    logic            grant;
    logic [MSB+1:0]  pool_d;
    logic [IW-1:0]   rr_ptr_d;

    assign enable = (state_q == ST_RUN) && (pool_q != '0) && !init_load_i;

    thymesisflow_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_valid_i (req_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .enable_i    (enable),
        .gnt_o       (req_ready_o),
        .idx_o       (gnt_idx_o)
    );

    assign grant    = |req_ready_o;
    // One extra bit so a full-scale return plus the pool shows up as overflow
    assign pool_d   = {1'b0, pool_q} + {1'b0, returned_credits_i} - {{(MSB+1){1'b0}}, grant};
    assign rr_ptr_d = (gnt_idx_o == IW'(NREQ-1)) ? '0 : gnt_idx_o + IW'(1);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_INIT;
            pool_q   <= '0;
            rr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (init_load_i) begin
            state_q  <= ST_RUN;
            pool_q   <= initial_credits_i;
            rr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (pool_d[MSB+1]) begin
                state_q <= ST_HALT;
                ovf_q   <= 1'b1;
            end else begin
                pool_q <= pool_d[MSB:0];
                if (grant) rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign credits_available_o = pool_q;
    assign state_o             = state_q;
    assign credit_overflow_o   = ovf_q;

endmodule

// File: doc/thymesisflow_credit_arb.md
# thymesisflow_credit_arb

Round-robin arbiter that shares one pool of TLX backpressure credits among NREQ command requesters in the AFU transmit path. It grants at most one requester per cycle, and only while a credit is held. It keeps the pool count itself: returned credits are added, and one credit is consumed per granted transfer. Count overflow is detected and halts granting until the pool is re-initialised.

## Interface
- NREQ, 4, number of requesters (2..8)
- MSB, 5, most significant bit of the credit count (count is MSB+1 bits wide)
- clock  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- init_load  in  1  one-cycle pulse: load pool from initial_credits, clear errors
- initial_credits  in  MSB+1  starting pool size from TLX
- returned_credits  in  MSB+1  credits returned by TLX this cycle
- req_valid  in  NREQ  per-requester transfer request
- req_ready  out  NREQ  one-hot grant; a transfer occurs on req_valid[i] & req_ready[i]
- gnt_idx  out  $clog2(NREQ)  index of the current grant; valid when any req_ready bit is set
- credits_available  out  MSB+1  registered pool count
- state  out  2  FSM state encoding
- credit_overflow  out  1  sticky: returned credits exceeded the count range

## Operation
- FSM states: INIT=0, RUN=1, HALT=2.
- Reset values:
  - state=INIT, pool=0, rr_ptr=0.
  - credit_overflow=0; req_ready=0; gnt_idx=0.
- INIT:
  - No grants; returned_credits are ignored.
  - init_load moves to RUN.
- RUN:
  - req_ready is asserted only when pool>0 and init_load=0.
  - Among the req_valid bits, the first at or after rr_ptr wins, searching upward and wrapping at NREQ-1→0.
  - req_ready is combinational from req_valid and registered state.
  - A requester must hold req_valid until it sees req_ready. req_ready never asserts for a bit with req_valid=0.
- Pool update in RUN uses an internal width of MSB+2 bits:
  - next = pool + returned_credits − grant, where grant is 1 when any req_ready bit is set.
  - If next[MSB+1]=1: pool holds its old value, credit_overflow←1, state→HALT.
- rr_ptr update: after a grant to index i, rr_ptr←(i+1) mod NREQ. With no grant, it is unchanged.
- HALT:
  - No grants; pool is frozen; returned_credits are ignored.
  - Exits only on init_load or on reset.
- init_load in any state:
  - Next cycle: pool=initial_credits, credit_overflow=0, rr_ptr=0, state=RUN.
  - In the init_load cycle itself, no grant is issued and returned_credits are discarded.
- Underflow cannot occur by construction, because grants are gated by pool>0. The bench asserts that the pool never decrements below 0.

## Timing
- Grant latency: req_ready asserts in the same cycle as req_valid when the pool is non-zero and state=RUN.
- Returned credits are visible on credits_available one cycle after they are presented. They can enable a grant in that following cycle, not earlier.
- Grant and return in the same cycle give a net pool change of returned_credits − 1.
  - Example: pool=1, return=1, grant gives pool=1 next cycle.
- Pool reaching 0 blocks req_ready from the next cycle on. It re-enables the cycle after a non-zero return.
- When a full-scale return (2^(MSB+1)−1) coincides with a grant, the net result is what is checked for overflow.
- Reset asserted mid-transfer:
  - All outputs go to their reset values asynchronously.
  - A grant that is pending in that cycle is not counted.
- The overflow flag and the HALT transition are visible one cycle after the offending return.

## Structure
- Shared package thymesisflow_credit_pkg holds:
  - state encodings ST_INIT, ST_RUN, ST_HALT;
  - default NREQ and MSB;
  - a function that computes the index width.
- Sub-module thymesisflow_rr_arbiter is combinational.
  - Inputs: req_valid, rr_ptr, enable. Outputs: one-hot grant, index.
  - It is reused by other schedulers.
- The top level holds the FSM, the pool register, rr_ptr and the overflow flag.

## Test plan
- Reset, then init_load with initial_credits=3; all four req_valid held high → grants to 0, 1, 2 on consecutive cycles. Then req_ready=0, credits_available=0, rr_ptr=3.
- From pool=0, returned_credits=2 for one cycle with req_valid=4'b1000 held → credits_available=2 next cycle. Grants follow in that cycle and the next, and the pool ends at 0.
- Fairness: pool=8, req_valid=4'b0101 held → grants alternate 0, 2, 0, 2. No grant to 1 or 3.
- Simultaneous events: pool=1 with grant and returned_credits=1 in the same cycle → pool stays 1, and the next grant goes to the next index.
- Overflow: MSB=5, pool=60, returned_credits=10 → credit_overflow=1, state=HALT, pool stays 60, no grants. init_load with initial_credits=16 → RUN, pool=16, flag cleared.
- Reset asserted asynchronously mid-cycle during an active grant with pool=5 → req_ready drops immediately, state=INIT, and no grants occur until init_load.
